// File: rtl/ck2ck_pkg.sv
// ck2ck_pkg: shared state types and constants for the clock-crossing FIFO blocks.
package ck2ck_pkg;
   localparam int CK2CK_ARB_MAX_REQ = 16;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACTIVE  = 2'd2,
      RELEASE = 2'd3
   } ty_Ck2CkArbStates;
   typedef enum logic [1:0] {
      FIFO_EMPTY  = 2'd0,
      FIFO_NORMAL = 2'd1,
      FIFO_FULL   = 2'd2
   } ty_Ck2CkFifoStates;
   function automatic int wrapInc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/ck2ck_fifo_push_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or above ptr (wrapping), one-hot out.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant
);
   int   idx;
   logic found;
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ck2ck_fifo_push_arb.sv
// ck2ck_fifo_push_arb: shares the FIFO push port round-robin and sequences the write-clock request.
// Define CK2CK_ARB_LOCK_EN to add the reqLock burst-lock port.
module ck2ck_fifo_push_arb
   import ck2ck_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int HOLD_CYC = 8
) (
   input  logic                         ck,
   input  logic                         srstN,
   input  logic [N_REQ-1:0]             reqValid,
   input  logic [N_REQ-1:0][DATA_W-1:0] reqData,
   output logic [N_REQ-1:0]             reqReady,
   output logic                         fifoPush,
   output logic [DATA_W-1:0]            fifoData,
   input  logic                         fifoFull,
   output logic                         ckReq,
   input  logic                         ckAck,
`ifdef CK2CK_ARB_LOCK_EN
   input  logic [N_REQ-1:0]             reqLock,
`endif
   output logic [1:0]                   arbSt
);
   localparam int PW = $clog2(N_REQ);
   ty_Ck2CkArbStates state, stateNxt;
   logic [PW-1:0]    ptr, ptrNxt, gIdx;
   logic [7:0]       idleCnt, idleCntNxt;
   logic [N_REQ-1:0] rrGrant, grant;
   logic             xferEn, busy, holdDone;

   rr_arbiter #(.N(N_REQ)) uArb (
      .req  (reqValid),
      .ptr  (ptr),
      .grant(rrGrant)
   );

`ifdef CK2CK_ARB_LOCK_EN
   logic          locked;
   logic [PW-1:0] lockIdx;
   assign grant = (locked && reqValid[lockIdx]) ? N_REQ'(1) << lockIdx : rrGrant;
   always_ff @(posedge ck) begin
      if (!srstN) begin
         locked  <= 1'b0;
         lockIdx <= '0;
      end else if (fifoPush) begin
         locked  <= reqLock[gIdx];
         lockIdx <= gIdx;
      end
   end
`else
   assign grant = rrGrant;
`endif

   always_comb begin
      gIdx = '0;
      for (int i = 0; i < N_REQ; i++) if (grant[i]) gIdx = PW'(i);
   end

   // Gating on srstN keeps a beat from leaking out in the reset cycle.
   assign xferEn   = srstN && state == ACTIVE && ckAck && !fifoFull;
   assign reqReady = xferEn ? grant : '0;
   assign fifoPush = |reqReady;
   assign fifoData = fifoPush ? reqData[gIdx] : '0;
   assign ckReq    = state == REQ || state == ACTIVE;
   assign arbSt    = state;
   // A full FIFO counts as pending work so the clock is held while producers are blocked.
   assign busy     = |reqValid || fifoFull;
   assign holdDone = !busy && (9'(idleCnt) + 9'd1 >= 9'(HOLD_CYC));

   always_comb begin
      stateNxt   = state;
      ptrNxt     = ptr;
      idleCntNxt = '0;
      case (state)
         IDLE:    if (|reqValid) stateNxt = REQ;
         REQ:     if (ckAck) stateNxt = ACTIVE;
         ACTIVE:  if (!ckAck) stateNxt = REQ;
                  else if (holdDone) stateNxt = RELEASE;
                  else idleCntNxt = busy ? 8'd0 : idleCnt + 8'd1;
         RELEASE: if (!ckAck) stateNxt = IDLE;
      endcase
      if (fifoPush) ptrNxt = PW'(wrapInc(int'(gIdx), N_REQ));
`ifdef CK2CK_ARB_LOCK_EN
      if (fifoPush && reqLock[gIdx]) ptrNxt = ptr;
`endif
   end

   always_ff @(posedge ck) begin
      if (!srstN) begin
         state   <= IDLE;
         ptr     <= '0;
         idleCnt <= '0;
      end else begin
         state   <= stateNxt;
         ptr     <= ptrNxt;
         idleCnt <= idleCntNxt;
      end
   end
endmodule

// File: tb/tb_ck2ck_fifo_push_arb.sv
// tb_ck2ck_fifo_push_arb: per-cycle vector table plus scoreboarded streams for the push arbiter.
`timescale 1ns/1ps
module tb_ck2ck_fifo_push_arb;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic       f;
      logic       a;
      logic [1:0] st;
      logic       rq;
      logic [3:0] rdy;
      logic [7:0] d;
   } vec_t;

   logic                ck = 1'b0;
   logic                srstN;
   logic [N-1:0]        reqValid, reqReady;
   logic [N-1:0][W-1:0] reqData;
   logic                fifoPush, fifoFull, ckReq, ckAck;
   logic [W-1:0]        fifoData;
   logic [1:0]          arbSt;
`ifdef CK2CK_ARB_LOCK_EN
   logic [N-1:0]        reqLock;
`endif
   int                  checks = 0;
   int                  errors = 0;
   int                  cycNo = 0;
   int                  lockLeft = 0;
   logic [W-1:0]        sbq[$];
   logic [3:0]          drvBeat[N];
   logic [3:0]          expBeat[N];
   vec_t                tbl[26];

   always #5 ck = ~ck;

   ck2ck_fifo_push_arb #(.N_REQ(N), .DATA_W(W), .HOLD_CYC(3)) dut (
      .ck      (ck),
      .srstN   (srstN),
      .reqValid(reqValid),
      .reqData (reqData),
      .reqReady(reqReady),
      .fifoPush(fifoPush),
      .fifoData(fifoData),
      .fifoFull(fifoFull),
      .ckReq   (ckReq),
      .ckAck   (ckAck),
`ifdef CK2CK_ARB_LOCK_EN
      .reqLock (reqLock),
`endif
      .arbSt   (arbSt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic nextCyc();
      @(posedge ck);
      #2;
      cycNo++;
   endtask

   task automatic addExp(input int p);
      sbq.push_back({4'(p), expBeat[p]});
      expBeat[p]++;
   endtask

   task automatic sbCycle(output bit pushed);
      logic [W-1:0] e;
      for (int i = 0; i < N; i++) reqData[i] = {4'(i), drvBeat[i]};
`ifdef CK2CK_ARB_LOCK_EN
      reqLock = (lockLeft > 0) ? 4'b0100 : 4'b0000;
`endif
      #1;
      pushed = fifoPush;
      if (fifoPush) begin
         if (sbq.size() == 0) chk("sb extra push", 32'(fifoData), 32'hFFFF_FFFF);
         else begin
            e = sbq.pop_front();
            chk("sb data", 32'(fifoData), 32'(e));
            chk("sb ready", 32'(reqReady), 32'(4'b0001 << e[7:4]));
         end
         for (int i = 0; i < N; i++) if (reqReady[i]) drvBeat[i]++;
         if (reqReady[2] && lockLeft > 0) lockLeft--;
      end
      nextCyc();
   endtask

   task automatic runSb(input string nm, output int first, output int last);
      bit p;
      first = -1;
      last  = -1;
      for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
         sbCycle(p);
         if (p) begin
            if (first < 0) first = cycNo;
            last = cycNo;
         end
      end
      chk({nm, " drained"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
   endtask

   initial begin
      int f, l;
      srstN    = 1'b0;
      reqValid = '0;
      fifoFull = 1'b0;
      ckAck    = 1'b1;
`ifdef CK2CK_ARB_LOCK_EN
      reqLock  = '0;
`endif
      for (int i = 0; i < N; i++) begin
         reqData[i] = 8'((i + 1) * 17);
         drvBeat[i] = '0;
         expBeat[i] = '0;
      end
      //            rst   valid  full  ack   state  ckReq ready  data
      tbl[0]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 8'h00};
      tbl[1]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 8'h00};
      tbl[2]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 8'h00};
      tbl[3]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 8'h00};
      tbl[4]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0, 8'h00};
      tbl[5]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 4'h1, 8'h11};
      tbl[6]  = '{1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[7]  = '{1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[8]  = '{1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[9]  = '{1'b1, 4'h2, 1'b0, 1'b1, 2'd3, 1'b0, 4'h0, 8'h00};
      tbl[10] = '{1'b1, 4'h2, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0, 8'h00};
      tbl[11] = '{1'b1, 4'h2, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 8'h00};
      tbl[12] = '{1'b1, 4'h2, 1'b0, 1'b0, 2'd1, 1'b1, 4'h0, 8'h00};
      tbl[13] = '{1'b1, 4'h2, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0, 8'h00};
      tbl[14] = '{1'b1, 4'h2, 1'b0, 1'b1, 2'd2, 1'b1, 4'h2, 8'h22};
      tbl[15] = '{1'b1, 4'hD, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[16] = '{1'b1, 4'hD, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[17] = '{1'b1, 4'hD, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4, 8'h33};
      tbl[18] = '{1'b1, 4'hD, 1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[19] = '{1'b1, 4'hD, 1'b0, 1'b0, 2'd1, 1'b1, 4'h0, 8'h00};
      tbl[20] = '{1'b1, 4'hD, 1'b0, 1'b1, 2'd1, 1'b1, 4'h0, 8'h00};
      tbl[21] = '{1'b1, 4'hD, 1'b0, 1'b1, 2'd2, 1'b1, 4'h8, 8'h44};
      tbl[22] = '{1'b1, 4'hD, 1'b0, 1'b1, 2'd2, 1'b1, 4'h1, 8'h11};
      tbl[23] = '{1'b1, 4'hD, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4, 8'h33};
      tbl[24] = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 8'h00};
      tbl[25] = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 8'h00};
      nextCyc();
      for (int k = 0; k < 26; k++) begin
         srstN    = tbl[k].rst;
         reqValid = tbl[k].v;
         fifoFull = tbl[k].f;
         ckAck    = tbl[k].a;
         #1;
         chk($sformatf("v%0d arbSt", k), 32'(arbSt), 32'(tbl[k].st));
         chk($sformatf("v%0d ckReq", k), 32'(ckReq), 32'(tbl[k].rq));
         chk($sformatf("v%0d reqReady", k), 32'(reqReady), 32'(tbl[k].rdy));
         chk($sformatf("v%0d fifoPush", k), 32'(fifoPush), 32'(|tbl[k].rdy));
         chk($sformatf("v%0d fifoData", k), 32'(fifoData), 32'(tbl[k].d));
         nextCyc();
      end
      srstN    = 1'b1;
      reqValid = '1;
      fifoFull = 1'b0;
      ckAck    = 1'b1;
      for (int k = 0; k < 10; k++) addExp(k % 4);
      runSb("rr", f, l);
      chk("rr back-to-back span", 32'(l - f), 32'd9);
      fifoFull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("full fifoPush", 32'(fifoPush), 32'd0);
         chk("full reqReady", 32'(reqReady), 32'd0);
         chk("full ckReq", 32'(ckReq), 32'd1);
         nextCyc();
      end
      fifoFull = 1'b0;
      addExp(2);
      addExp(3);
      addExp(0);
      addExp(1);
      runSb("resume", f, l);
      chk("resume back-to-back span", 32'(l - f), 32'd3);
`ifdef CK2CK_ARB_LOCK_EN
      reqValid = 4'b1100;
      lockLeft = 3;
      for (int k = 0; k < 4; k++) addExp(2);
      addExp(3);
      runSb("lock", f, l);
`endif
      reqValid = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
